mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one memory port between instruction fetch (if_stage) and load/store (mem_stage).
//  Serialises both onto a single valid/ready bus with one outstanding transaction.
//  Sits between the core stages and the memory model or bus bridge.
//  Provides round-robin fairness, per-requester response routing and a response watchdog.
// PARAMETERS
//  ADDR_W          64   address width
//  DATA_W          64   bus data width; byte strobes are DATA_W/8
//  TIMEOUT_CYCLES  255  maximum WAIT cycles before a forced response
//  CNT_W           8    watchdog counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES
// PORTS
//  clock           in   1         clock
//  reset           in   1         synchronous, active-high reset
//  if_req_valid    in   1         fetch request
//  if_req_addr     in   ADDR_W    fetch address, 4-byte aligned
//  if_req_ready    out  1         fetch request accepted this cycle
//  if_resp_valid   out  1         1-cycle pulse: instruction returned
//  if_resp_inst    out  32        instruction word
//  mem_req_valid   in   1         load/store request
//  mem_req_wen     in   1         1 = store, 0 = load
//  mem_req_addr    in   ADDR_W    data address
//  mem_req_wdata   in   DATA_W    store data
//  mem_req_wstrb   in   DATA_W/8  store byte enables
//  mem_req_ready   out  1         data request accepted this cycle
//  mem_resp_valid  out  1         1-cycle pulse: load data returned or store completed
//  mem_resp_rdata  out  DATA_W    load data; 0 for stores
//  bus_req_valid   out  1         downstream request
//  bus_req_ready   in   1         downstream request accepted
//  bus_req_addr    out  ADDR_W    downstream address
//  bus_req_wen     out  1         downstream write enable
//  bus_req_wdata   out  DATA_W    downstream write data
//  bus_req_wstrb   out  DATA_W/8  downstream strobes; 0 for reads
//  bus_resp_valid  in   1         downstream response
//  bus_resp_rdata  in   DATA_W    downstream read data
//  busy            out  1         state is not IDLE
//  timeout         out  1         sticky; set by a watchdog expiry, cleared only by reset
// BEHAVIOUR
//  - Reset: state=IDLE; every output 0; last_grant=IF; watchdog=0; timeout=0.
//  - FSM states: IDLE -> REQ -> WAIT -> RESP -> IDLE.
//  - IDLE, one requester valid: grant it.
//  - IDLE, both valid: grant the requester not in last_grant.
//  - IDLE grant: pulse its *_req_ready combinationally in that cycle (T); latch addr/wen/wdata/wstrb
//    and the owner; update last_grant; go to REQ. If no requester is valid, stay in IDLE.
//  - REQ: bus_req_* driven from latched registers and held stable while bus_req_valid=1.
//    On bus_req_valid & bus_req_ready, go to WAIT and clear the watchdog.
//  - Fetch owner presents wen=0 and wstrb=0.
//  - WAIT: watchdog increments every cycle.
//    - On bus_resp_valid: register the data and go to RESP.
//    - Watchdog reaching TIMEOUT_CYCLES first: data=0, set timeout, go to RESP.
//  - RESP: pulse the owner's *_resp_valid for exactly 1 cycle, then go to IDLE.
//    The other requester's resp_valid stays 0.
//  - if_resp_inst = addr[2] ? rdata[63:32] : rdata[31:0]. Store responses return rdata=0.
//  - Minimum latency with zero-wait bus: accept at T, bus req at T+1, bus resp at T+2,
//    *_resp_valid at T+3. Next accept earliest at T+4.
//  - bus_resp_valid outside WAIT (including the cycle of the bus handshake) is ignored.
//  - A requester may drop valid while unserved; it must hold its payload stable until ready.
//  - Reset mid-transaction abandons it: no response is delivered, and a late bus_resp is ignored.
// STRUCTURE
//  - defines.v gains: `ARB_ST_IDLE/REQ/WAIT/RESP` (2-bit encodings), `ARB_OWNER_IF/MEM`, `ARB_ST_BUS`.
//  - Sub-module rr_arbiter2: 2-way round-robin picker holding last_grant. Inputs req[1:0] and
//    advance; output grant[1:0], one-hot or zero. Everything else stays in mem_arbiter.
// TESTING
//  - Fetch only, addr 0x80000004, bus returns 0x11223344_55667788 one cycle after handshake
//    -> if_resp_inst=0x11223344 at T+3; mem_resp_valid stays 0.
//  - Both valid in IDLE after reset -> MEM granted first (last_grant=IF), then IF.
//    Both held valid -> grants alternate MEM, IF, MEM, IF.
//  - Store addr 0x80001000, wdata 0xDEADBEEF, wstrb 0x0F, bus_req_ready low 3 cycles
//    -> bus_req_* stable for 4 cycles; mem_resp_valid pulses with rdata=0.
//  - Bus never responds -> after TIMEOUT_CYCLES in WAIT: resp pulse with data 0; timeout=1 and
//    stays 1; next request is served normally.
//  - Reset asserted in WAIT, then spurious bus_resp_valid -> no resp pulse; busy=0; all outputs 0.
//  - Spurious bus_resp_valid while IDLE -> no output change; the subsequent fetch returns its own data.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared types and constants for the instruction/data memory arbiter:
//   FSM state encoding, transaction owner encoding, requester bit positions
//   in the round-robin request vector, and the fetch word-select helper.
//   No ports (package).
package mem_arbiter_pkg;

  // Width of the arbiter state field.
  localparam int ARB_ST_BUS = 2;

  typedef enum logic [ARB_ST_BUS-1:0] {
    ARB_ST_IDLE = 2'd0,
    ARB_ST_REQ  = 2'd1,
    ARB_ST_WAIT = 2'd2,
    ARB_ST_RESP = 2'd3
  } arb_state_e;

  // Owner of the outstanding transaction; also the encoding of last_grant.
  typedef enum logic {
    ARB_OWNER_IF  = 1'b0,
    ARB_OWNER_MEM = 1'b1
  } arb_owner_e;

  // Bit positions inside the 2-bit request / grant vectors.
  localparam int REQ_IDX_IF  = 0;
  localparam int REQ_IDX_MEM = 1;

  // Pick the 32-bit instruction out of a 64-bit beat using address bit 2.
  function automatic logic [31:0] inst_select(input logic word_sel, input logic [63:0] beat);
    logic [31:0] word_s;
    if (word_sel) begin
      word_s = beat[63:32];
    end else begin
      word_s = beat[31:0];
    end
    return word_s;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// rr_arbiter2
//   Two-way round-robin picker. Holds last_grant internally.
//   Ports:
//     clock, reset   clock and synchronous active-high reset (last_grant -> IF)
//     req[1:0]       bit0 = fetch, bit1 = load/store
//     advance        commit the current grant as the new last_grant
//     grant[1:0]     one-hot winner, or zero when nobody requests
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  arb_owner_e last_grant_r;

  // Winner selection: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
        if (last_grant_r == ARB_OWNER_IF) begin
          grant = 2'b10;
        end else begin
          grant = 2'b01;
        end
      end
      default: grant = 2'b00;
    endcase
  end

  // last_grant register, updated only when a grant is actually taken.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_r <= ARB_OWNER_IF;
    end else if (advance && (grant != 2'b00)) begin
      last_grant_r <= arb_owner_e'(grant[REQ_IDX_MEM]);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one valid/ready memory port between instruction fetch and
//   load/store, one outstanding transaction at a time, with round-robin
//   fairness, per-requester response routing and a response watchdog.
//   Ports:
//     clock, reset                     clock, synchronous active-high reset
//     if_req_*  / if_resp_*            fetch request (addr) and instruction response
//     mem_req_* / mem_resp_*           load/store request and response (rdata=0 for stores)
//     bus_req_* / bus_resp_*           downstream single-port bus
//     busy                             a transaction is in flight
//     timeout                          sticky watchdog-expiry flag (cleared by reset only)
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_req_ready,
  output logic                if_resp_valid,
  output logic [31:0]         if_resp_inst,
  input  logic                mem_req_valid,
  input  logic                mem_req_wen,
  input  logic [ADDR_W-1:0]   mem_req_addr,
  input  logic [DATA_W-1:0]   mem_req_wdata,
  input  logic [DATA_W/8-1:0] mem_req_wstrb,
  output logic                mem_req_ready,
  output logic                mem_resp_valid,
  output logic [DATA_W-1:0]   mem_resp_rdata,
  output logic                bus_req_valid,
  input  logic                bus_req_ready,
  output logic [ADDR_W-1:0]   bus_req_addr,
  output logic                bus_req_wen,
  output logic [DATA_W-1:0]   bus_req_wdata,
  output logic [DATA_W/8-1:0] bus_req_wstrb,
  input  logic                bus_resp_valid,
  input  logic [DATA_W-1:0]   bus_resp_rdata,
  output logic                busy,
  output logic                timeout
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_e          state_r;
  arb_state_e          state_nxt_s;
  arb_owner_e          owner_r;
  logic [ADDR_W-1:0]   addr_r;
  logic                wen_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [STRB_W-1:0]   wstrb_r;
  logic [DATA_W-1:0]   rdata_r;
  logic [CNT_W-1:0]    wdog_r;
  logic                timeout_r;
  logic [1:0]          grant_s;
  logic                idle_s;
  logic                wdog_expire_s;

  assign idle_s = (state_r == ARB_ST_IDLE);
  // Last permitted WAIT cycle: the counter starts at 0 on the handshake, so
  // this fires on the TIMEOUT_CYCLES-th WAIT cycle unless a response arrives.
  assign wdog_expire_s = (wdog_r == CNT_W'(TIMEOUT_CYCLES - 1));

  rr_arbiter2 u_rr (
    .clock   (clock),
    .reset   (reset),
    .req     ({mem_req_valid, if_req_valid}),
    .advance (idle_s),
    .grant   (grant_s)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ARB_ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ARB_ST_IDLE: begin
        if (grant_s != 2'b00) begin
          state_nxt_s = ARB_ST_REQ;
        end else begin
          state_nxt_s = ARB_ST_IDLE;
        end
      end
      ARB_ST_REQ: begin
        if (bus_req_ready) begin
          state_nxt_s = ARB_ST_WAIT;
        end else begin
          state_nxt_s = ARB_ST_REQ;
        end
      end
      ARB_ST_WAIT: begin
        if (bus_resp_valid || wdog_expire_s) begin
          state_nxt_s = ARB_ST_RESP;
        end else begin
          state_nxt_s = ARB_ST_WAIT;
        end
      end
      ARB_ST_RESP: state_nxt_s = ARB_ST_IDLE;
      default:     state_nxt_s = ARB_ST_IDLE;
    endcase
  end

  // Request latch, watchdog, response data and sticky timeout flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      owner_r   <= ARB_OWNER_IF;
      addr_r    <= '0;
      wen_r     <= 1'b0;
      wdata_r   <= '0;
      wstrb_r   <= '0;
      rdata_r   <= '0;
      wdog_r    <= '0;
      timeout_r <= 1'b0;
    end else begin
      case (state_r)
        ARB_ST_IDLE: begin
          if (grant_s[REQ_IDX_MEM]) begin
            owner_r <= ARB_OWNER_MEM;
            addr_r  <= mem_req_addr;
            wen_r   <= mem_req_wen;
            wdata_r <= mem_req_wdata;
            wstrb_r <= mem_req_wstrb;
          end else if (grant_s[REQ_IDX_IF]) begin
            // Fetches are always reads with no strobes.
            owner_r <= ARB_OWNER_IF;
            addr_r  <= if_req_addr;
            wen_r   <= 1'b0;
            wdata_r <= '0;
            wstrb_r <= '0;
          end
        end
        ARB_ST_REQ: begin
          if (bus_req_ready) begin
            wdog_r <= '0;
          end
        end
        ARB_ST_WAIT: begin
          wdog_r <= wdog_r + CNT_W'(1);
          if (bus_resp_valid) begin
            // Stores complete with zero data regardless of what the bus returns.
            if (wen_r) begin
              rdata_r <= '0;
            end else begin
              rdata_r <= bus_resp_rdata;
            end
          end else if (wdog_expire_s) begin
            rdata_r   <= '0;
            timeout_r <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode: request handshakes, bus drive and response routing.
  always_comb begin
    if_req_ready   = 1'b0;
    mem_req_ready  = 1'b0;
    bus_req_valid  = 1'b0;
    bus_req_addr   = '0;
    bus_req_wen    = 1'b0;
    bus_req_wdata  = '0;
    bus_req_wstrb  = '0;
    if_resp_valid  = 1'b0;
    if_resp_inst   = 32'd0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    busy           = !idle_s;
    timeout        = timeout_r;

    if (idle_s) begin
      if_req_ready  = grant_s[REQ_IDX_IF];
      mem_req_ready = grant_s[REQ_IDX_MEM];
    end else begin
      if_req_ready  = 1'b0;
      mem_req_ready = 1'b0;
    end

    if (state_r == ARB_ST_REQ) begin
      bus_req_valid = 1'b1;
      bus_req_addr  = addr_r;
      bus_req_wen   = wen_r;
      bus_req_wdata = wdata_r;
      bus_req_wstrb = wstrb_r;
    end else begin
      bus_req_valid = 1'b0;
    end

    if (state_r == ARB_ST_RESP) begin
      if (owner_r == ARB_OWNER_IF) begin
        if_resp_valid = 1'b1;
        if_resp_inst  = inst_select(addr_r[2], rdata_r[63:0]);
      end else begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rdata_r;
      end
    end else begin
      if_resp_valid  = 1'b0;
      mem_resp_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter: a transaction-level reference model
//   compared every cycle, a configurable bus responder, and literal
//   expectations for the headline scenarios.
module tb_mem_arbiter;

  localparam int TMO = 255;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req_valid;
  logic [63:0] if_req_addr;
  logic        if_req_ready;
  logic        if_resp_valid;
  logic [31:0] if_resp_inst;
  logic        mem_req_valid;
  logic        mem_req_wen;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wstrb;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [63:0] bus_req_addr;
  logic        bus_req_wen;
  logic [63:0] bus_req_wdata;
  logic [7:0]  bus_req_wstrb;
  logic        bus_resp_valid;
  logic [63:0] bus_resp_rdata;
  logic        busy;
  logic        timeout;

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
    .clock(clock), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_inst(if_resp_inst),
    .mem_req_valid(mem_req_valid), .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_addr(bus_req_addr),
    .bus_req_wen(bus_req_wen), .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
    .bus_resp_valid(bus_resp_valid), .bus_resp_rdata(bus_resp_rdata),
    .busy(busy), .timeout(timeout)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit          m_active = 1'b0;   // a transaction has been accepted
  bit          m_issued = 1'b0;   // bus handshake done
  bit          m_done = 1'b0;     // response ready to be delivered this cycle
  bit          m_owner = 1'b0;    // 0 = fetch, 1 = load/store
  bit          m_last_mem = 1'b0; // last grant went to load/store
  bit          m_timeout = 1'b0;
  int          m_waited = 0;
  logic [63:0] m_addr = 64'd0;
  logic [63:0] m_wdata = 64'd0;
  logic [63:0] m_data = 64'd0;
  logic [7:0]  m_wstrb = 8'd0;
  bit          m_wen = 1'b0;

  function automatic bit exp_grant_mem();
    return !m_active && mem_req_valid && (!if_req_valid || !m_last_mem);
  endfunction

  function automatic bit exp_grant_if();
    return !m_active && if_req_valid && (!mem_req_valid || m_last_mem);
  endfunction

  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      m_active = 1'b0; m_issued = 1'b0; m_done = 1'b0;
      m_last_mem = 1'b0; m_timeout = 1'b0; m_waited = 0;
    end else if (!m_active) begin
      if (exp_grant_mem()) begin
        m_active = 1'b1; m_owner = 1'b1; m_last_mem = 1'b1;
        m_addr = mem_req_addr; m_wen = mem_req_wen;
        m_wdata = mem_req_wdata; m_wstrb = mem_req_wstrb;
      end else if (exp_grant_if()) begin
        m_active = 1'b1; m_owner = 1'b0; m_last_mem = 1'b0;
        m_addr = if_req_addr; m_wen = 1'b0; m_wdata = 64'd0; m_wstrb = 8'd0;
      end
    end else if (!m_issued) begin
      if (bus_req_ready) begin
        m_issued = 1'b1; m_waited = 0;
      end
    end else if (!m_done) begin
      m_waited++;
      if (bus_resp_valid) begin
        m_done = 1'b1;
        m_data = m_wen ? 64'd0 : bus_resp_rdata;
      end else if (m_waited >= TMO) begin
        m_done = 1'b1; m_data = 64'd0; m_timeout = 1'b1;
      end
    end else begin
      m_active = 1'b0; m_issued = 1'b0; m_done = 1'b0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    logic [63:0] d;
    d = m_data;
    check("busy", busy, m_active);
    check("timeout", timeout, m_timeout);
    check("if_req_ready", if_req_ready, exp_grant_if());
    check("mem_req_ready", mem_req_ready, exp_grant_mem());
    check("bus_req_valid", bus_req_valid, m_active && !m_issued);
    if (m_active && !m_issued) begin
      check("bus_req_addr", bus_req_addr, m_addr);
      check("bus_req_wen", bus_req_wen, m_wen);
      check("bus_req_wstrb", bus_req_wstrb, m_wstrb);
      if (m_wen) check("bus_req_wdata", bus_req_wdata, m_wdata);
    end
    check("if_resp_valid", if_resp_valid, m_active && m_done && !m_owner);
    check("mem_resp_valid", mem_resp_valid, m_active && m_done && m_owner);
    if (m_active && m_done && !m_owner)
      check("if_resp_inst", if_resp_inst, m_addr[2] ? d[63:32] : d[31:0]);
    if (m_active && m_done && m_owner)
      check("mem_resp_rdata", mem_resp_rdata, d);
  end

  // ---------------- bus responder ----------------
  int          ready_delay = 0;
  bit          resp_en = 1'b1;
  logic [63:0] resp_data = 64'd0;
  bit          resp_due = 1'b0;
  int          ready_cnt = 0;

  // Holds ready low ready_delay cycles, answers one cycle after the handshake.
  always @(posedge clock) begin
    #1;
    bus_resp_valid = 1'b0;
    if (resp_due) begin
      bus_resp_valid = 1'b1;
      bus_resp_rdata = resp_data;
    end
    resp_due = 1'b0;
    if (bus_req_valid) begin
      if (ready_cnt >= ready_delay) begin
        bus_req_ready = 1'b1; resp_due = resp_en; ready_cnt = 0;
      end else begin
        bus_req_ready = 1'b0; ready_cnt++;
      end
    end else begin
      bus_req_ready = 1'b0; ready_cnt = 0;
    end
  end

  // Grant log and bus-request duration counter.
  int grants[$];
  int gcyc[$];
  int breq_cycles = 0;
  always @(negedge clock) begin
    if (if_req_ready) begin grants.push_back(0); gcyc.push_back(cyc); end
    if (mem_req_ready) begin grants.push_back(1); gcyc.push_back(cyc); end
    if (bus_req_valid) breq_cycles++;
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_accept(input bit is_mem, output int acc);
    bit seen = 1'b0;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (is_mem ? mem_req_ready : if_req_ready) begin
        acc = cyc; seen = 1'b1; break;
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL accept_bound: no ready within 50 cycles (wanted ready)");
    end
    tick();
    if (is_mem) mem_req_valid = 1'b0; else if_req_valid = 1'b0;
  endtask

  task automatic wait_resp(input bit is_mem, input int acc, output int lat, output logic [63:0] data);
    bit seen = 1'b0;
    lat = -1;
    data = 64'd0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (is_mem ? mem_resp_valid : if_resp_valid) begin
        lat = cyc - acc;
        data = is_mem ? mem_resp_rdata : {32'd0, if_resp_inst};
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL resp_bound: no response within 400 cycles (wanted a pulse)");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int acc;
    int lat;
    logic [63:0] data;
    bit pulse;

    reset = 1'b1;
    if_req_valid = 1'b0; if_req_addr = 64'd0;
    mem_req_valid = 1'b0; mem_req_wen = 1'b0; mem_req_addr = 64'd0;
    mem_req_wdata = 64'd0; mem_req_wstrb = 8'd0;
    bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_rdata = 64'd0;
    tick(); tick();
    reset = 1'b0;
    @(negedge clock);
    check("rst_busy", busy, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_bus_req_valid", bus_req_valid, 1'b0);
    check("rst_bus_req_addr", bus_req_addr, 64'd0);
    check("rst_if_resp", {if_resp_valid, if_resp_inst}, 64'd0);
    check("rst_mem_resp", {mem_resp_valid, mem_resp_rdata}, 64'd0);

    // Fetch only, upper word selected.
    tick();
    resp_data = 64'h11223344_55667788;
    if_req_addr = 64'h8000_0004; if_req_valid = 1'b1;
    wait_accept(1'b0, acc);
    wait_resp(1'b0, acc, lat, data);
    check("fetch_latency", lat, 64'd3);
    check("fetch_inst", data, 64'h11223344);

    // Both valid after reset: MEM first, then alternate.
    tick();
    grants.delete(); gcyc.delete();
    resp_data = 64'h0000_0000_0BAD_F00D;
    if_req_addr = 64'h100;
    mem_req_addr = 64'h200; mem_req_wen = 1'b0; mem_req_wstrb = 8'hFF;
    if_req_valid = 1'b1; mem_req_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (grants.size() >= 4) break;
    end
    tick();
    if_req_valid = 1'b0; mem_req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (!busy) break;
    end
    check("grant_count", grants.size(), 64'd4);
    if (grants.size() >= 4) begin
      check("grant0_mem", grants[0], 64'd1);
      check("grant1_if", grants[1], 64'd0);
      check("grant2_mem", grants[2], 64'd1);
      check("grant3_if", grants[3], 64'd0);
      check("grant_spacing", gcyc[1] - gcyc[0], 64'd4);
    end

    // Store with bus_req_ready low for 3 cycles.
    tick();
    ready_delay = 3; breq_cycles = 0;
    resp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    mem_req_addr = 64'h8000_1000; mem_req_wen = 1'b1;
    mem_req_wdata = 64'hDEAD_BEEF; mem_req_wstrb = 8'h0F; mem_req_valid = 1'b1;
    wait_accept(1'b1, acc);
    wait_resp(1'b1, acc, lat, data);
    check("store_rdata", data, 64'd0);
    check("store_latency", lat, 64'd6);
    check("store_breq_cycles", breq_cycles, 64'd4);
    ready_delay = 0;

    // Load returns bus data.
    tick();
    resp_data = 64'hCAFE_F00D_1234_5678;
    mem_req_addr = 64'h8000_2008; mem_req_wen = 1'b0; mem_req_wstrb = 8'hFF; mem_req_valid = 1'b1;
    wait_accept(1'b1, acc);
    wait_resp(1'b1, acc, lat, data);
    check("load_rdata", data, 64'hCAFE_F00D_1234_5678);
    check("load_latency", lat, 64'd3);

    // Bus never responds: watchdog forces a zero response.
    tick();
    resp_en = 1'b0;
    if_req_addr = 64'h8000_0000; if_req_valid = 1'b1;
    wait_accept(1'b0, acc);
    wait_resp(1'b0, acc, lat, data);
    check("tmo_latency", lat, 64'd257);
    check("tmo_data", data, 64'd0);
    check("tmo_flag", timeout, 1'b1);
    tick();
    resp_en = 1'b1;
    resp_data = 64'hAAAA_BBBB_CCCC_DDDD;
    if_req_addr = 64'h8000_0008; if_req_valid = 1'b1;
    wait_accept(1'b0, acc);
    wait_resp(1'b0, acc, lat, data);
    check("post_tmo_inst", data, 64'hCCCC_DDDD);
    check("post_tmo_latency", lat, 64'd3);
    check("tmo_sticky", timeout, 1'b1);

    // Reset in WAIT, then a late bus response.
    tick();
    resp_en = 1'b0;
    if_req_addr = 64'h40; if_req_valid = 1'b1;
    wait_accept(1'b0, acc);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus_resp_valid = 1'b1; bus_resp_rdata = 64'h1234_5678_9ABC_DEF0;
    pulse = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (if_resp_valid || mem_resp_valid || busy || bus_req_valid) pulse = 1'b1;
    end
    check("rst_wait_quiet", pulse, 1'b0);
    check("rst_wait_timeout", timeout, 1'b0);
    check("rst_wait_inst", if_resp_inst, 64'd0);
    resp_en = 1'b1;

    // Spurious response while IDLE, then a normal fetch.
    tick();
    bus_resp_valid = 1'b1; bus_resp_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
    @(negedge clock);
    check("spur_no_if_resp", if_resp_valid, 1'b0);
    check("spur_not_busy", busy, 1'b0);
    tick();
    resp_data = 64'h0102_0304_0506_0708;
    if_req_addr = 64'h8000_0004; if_req_valid = 1'b1;
    wait_accept(1'b0, acc);
    wait_resp(1'b0, acc, lat, data);
    check("spur_fetch_inst", data, 64'h0102_0304);
    check("spur_fetch_latency", lat, 64'd3);

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
